// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared types and constants for the writeback arbiter
// Purpose: register-address width, register count, arbiter FSM encoding and a
//          one-hot helper used by the busy scoreboard.
// Ports:   none (package).
package writeback_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    PIPE_PRI = 1'b0,
    LU_FORCE = 1'b1
  } arb_state_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
    return NUM_REGS'(1) << addr;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - writeback bus bundle: pipe/long-unit sources, issue, decode, regfile port
// Purpose: groups every non-clock/reset signal of the writeback stage.
// Ports:   slave  - arbiter view (sources/issue/decode in; hold, ready, stall, we/wa/wd out)
//          master - driver view (mirror of slave)
interface writeback_arbiter_if #(
  parameter int WIDTH = 32
);
  import writeback_arbiter_pkg::*;

  logic             pipe_valid;
  reg_addr_t        pipe_wa;
  logic [WIDTH-1:0] pipe_wd;
  logic             pipe_hold;

  logic             lu_valid;
  logic             lu_ready;
  reg_addr_t        lu_wa;
  logic [WIDTH-1:0] lu_wd;

  logic             iss_valid;
  reg_addr_t        iss_rd;

  reg_addr_t        ra0;
  reg_addr_t        ra1;
  logic             stall;

  logic             we;
  reg_addr_t        wa;
  logic [WIDTH-1:0] wd;

  modport slave (
    input  pipe_valid, pipe_wa, pipe_wd,
    output pipe_hold,
    input  lu_valid, lu_wa, lu_wd,
    output lu_ready,
    input  iss_valid, iss_rd, ra0, ra1,
    output stall, we, wa, wd
  );

  modport master (
    output pipe_valid, pipe_wa, pipe_wd,
    input  pipe_hold,
    output lu_valid, lu_wa, lu_wd,
    input  lu_ready,
    output iss_valid, iss_rd, ra0, ra1,
    input  stall, we, wa, wd
  );

endinterface

// File: rtl/writeback_arbiter_scoreboard.sv
// rtl/writeback_arbiter_scoreboard.sv - busy scoreboard of registers with outstanding long-latency writes
// Purpose: 32-bit busy vector with set-on-issue / clear-on-writeback and two RAW lookups.
// Ports:   clk, rst (async, active-low)
//          set_en/set_addr - long-latency op issued to set_addr
//          clr_en/clr_addr - long-unit result accepted for clr_addr
//          ra0/ra1         - decode source registers
//          stall           - either source register is busy
module wb_scoreboard
  import writeback_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t ra0,
  input  reg_addr_t ra1,
  output logic      stall
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // Clear is applied before set so a new issue to the register being
  // written back leaves it outstanding. Register 0 is never marked busy.
  always_comb begin
    busy_next = busy;
    if (clr_en) begin
      busy_next = busy_next & ~reg_onehot(clr_addr);
    end
    if (set_en && (set_addr != '0)) begin
      busy_next = busy_next | reg_onehot(set_addr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign stall = ((ra0 != '0) && busy[ra0]) || ((ra1 != '0) && busy[ra1]);

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges pipeline and long-unit results onto the single regfile write port
// Purpose: pipeline-priority arbitration with a starvation escape for the long unit,
//          registered regfile write port, and RAW stall from the busy scoreboard.
// Ports:   clk - rising-edge clock
//          rst - asynchronous active-low reset
//          wb  - writeback_arbiter_if.slave (pipe_*, lu_*, iss_*, ra0/ra1, stall, we/wa/wd)
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  writeback_arbiter_if.slave    wb
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

  arb_state_e       state, state_next;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_next;

  logic             lu_ready_c;
  logic             pipe_hold_c;
  logic             lu_accept;
  logic             sel_en;
  reg_addr_t        sel_wa;
  logic [WIDTH-1:0] sel_wd;

  // Arbiter FSM: next state, handshake outputs and starvation counter.
  always_comb begin
    state_next      = state;
    starve_cnt_next = starve_cnt;
    lu_ready_c      = !wb.pipe_valid;
    pipe_hold_c     = 1'b0;
    lu_accept       = 1'b0;
    case (state)
      PIPE_PRI: begin
        lu_ready_c  = !wb.pipe_valid;
        pipe_hold_c = 1'b0;
        lu_accept   = wb.lu_valid && lu_ready_c;
        if (lu_accept) begin
          starve_cnt_next = '0;
        end else if (wb.lu_valid) begin
          // Blocked this cycle; after STARVE_LIMIT blocked cycles the
          // long unit takes the port on the following cycle.
          if (starve_cnt == CNT_LAST) begin
            state_next = LU_FORCE;
          end else begin
            starve_cnt_next = starve_cnt + 1'b1;
          end
        end
      end
      LU_FORCE: begin
        lu_ready_c      = 1'b1;
        pipe_hold_c     = wb.pipe_valid;
        lu_accept       = wb.lu_valid;
        state_next      = PIPE_PRI;
        starve_cnt_next = '0;
      end
      default: begin
        state_next      = PIPE_PRI;
        starve_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= PIPE_PRI;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  assign wb.lu_ready  = lu_ready_c;
  assign wb.pipe_hold = pipe_hold_c;

  // One source per cycle: an accepted long-unit result beats the pipeline,
  // and pipe_hold already keeps the pipeline out when the long unit is forced.
  always_comb begin
    sel_en = 1'b0;
    sel_wa = '0;
    sel_wd = '0;
    if (lu_accept) begin
      sel_en = 1'b1;
      sel_wa = wb.lu_wa;
      sel_wd = wb.lu_wd;
    end else if (wb.pipe_valid && !pipe_hold_c) begin
      sel_en = 1'b1;
      sel_wa = wb.pipe_wa;
      sel_wd = wb.pipe_wd;
    end
  end

  // Register 0 is hard-wired zero: the source is consumed but no write issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb.we <= 1'b0;
      wb.wa <= '0;
      wb.wd <= '0;
    end else begin
      wb.we <= sel_en && (sel_wa != '0);
      if (sel_en) begin
        wb.wa <= sel_wa;
        wb.wd <= sel_wd;
      end
    end
  end

  wb_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (wb.iss_valid),
    .set_addr (wb.iss_rd),
    .clr_en   (lu_accept),
    .clr_addr (wb.lu_wa),
    .ra0      (wb.ra0),
    .ra1      (wb.ra1),
    .stall    (wb.stall)
  );

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - randomized self-checking bench for writeback_arbiter
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int WIDTH        = 32;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  writeback_arbiter_if #(.WIDTH(WIDTH)) bus ();

  writeback_arbiter #(
    .WIDTH        (WIDTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0]      m_busy;
  int               m_refused;
  logic             exp_we;
  logic [4:0]       exp_wa;
  logic [WIDTH-1:0] exp_wd;
  int               lu_acc_cnt;
  int               lu_wr_cnt;
  logic             last_lu_acc;
  logic             last_pipe_held;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs are already driven; check combinational outputs, advance the
  // model one clock, then check the registered write port.
  task automatic cycle(input string tag);
    logic forced, e_ready, e_hold, e_stall, acc;
    #1;
    forced  = (m_refused >= STARVE_LIMIT);
    e_ready = forced || !bus.pipe_valid;
    e_hold  = forced && bus.pipe_valid;
    e_stall = ((bus.ra0 != 0) && m_busy[bus.ra0]) || ((bus.ra1 != 0) && m_busy[bus.ra1]);
    check_eq({tag, ".lu_ready"}, 64'(bus.lu_ready), 64'(e_ready));
    check_eq({tag, ".pipe_hold"}, 64'(bus.pipe_hold), 64'(e_hold));
    check_eq({tag, ".stall"}, 64'(bus.stall), 64'(e_stall));
    acc = bus.lu_valid && e_ready;
    if (acc) begin
      exp_we = (bus.lu_wa != 0);
      exp_wa = bus.lu_wa;
      exp_wd = bus.lu_wd;
      if (bus.lu_wa != 0) lu_acc_cnt++;
    end else if (bus.pipe_valid && !e_hold) begin
      exp_we = (bus.pipe_wa != 0);
      exp_wa = bus.pipe_wa;
      exp_wd = bus.pipe_wd;
    end else begin
      exp_we = 1'b0;
    end
    if (acc) m_busy[bus.lu_wa] = 1'b0;
    if (bus.iss_valid && (bus.iss_rd != 0)) m_busy[bus.iss_rd] = 1'b1;
    if (forced || acc) m_refused = 0;
    else if (bus.lu_valid) m_refused++;
    last_lu_acc    = acc;
    last_pipe_held = e_hold;
    @(posedge clk);
    #1;
    check_eq({tag, ".we"}, 64'(bus.we), 64'(exp_we));
    if (exp_we) begin
      check_eq({tag, ".wa"}, 64'(bus.wa), 64'(exp_wa));
      check_eq({tag, ".wd"}, 64'(bus.wd), 64'(exp_wd));
    end
    if (bus.we && (bus.wd[31:24] == 8'hA5)) lu_wr_cnt++;
  endtask

  task automatic clear_inputs();
    bus.pipe_valid = 1'b0; bus.pipe_wa = '0; bus.pipe_wd = '0;
    bus.lu_valid   = 1'b0; bus.lu_wa   = '0; bus.lu_wd   = '0;
    bus.iss_valid  = 1'b0; bus.iss_rd  = '0;
    bus.ra0        = '0;   bus.ra1     = '0;
  endtask

  initial begin
    clear_inputs();
    m_busy = '0; m_refused = 0; exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
    lu_acc_cnt = 0; lu_wr_cnt = 0; last_lu_acc = 1'b0; last_pipe_held = 1'b0;

    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.we", 64'(bus.we), 64'd0);
    check_eq("reset.wa", 64'(bus.wa), 64'd0);
    check_eq("reset.wd", 64'(bus.wd), 64'd0);
    check_eq("reset.stall", 64'(bus.stall), 64'd0);
    rst = 1'b1;

    // 1. Reset mid-write with busy = 0x0000_0F00
    for (int r = 8; r < 12; r++) begin
      bus.iss_valid = 1'b1; bus.iss_rd = 5'(r);
      cycle("t1.iss");
    end
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.pipe_valid = 1'b1; bus.pipe_wa = 5'd3; bus.pipe_wd = 32'h1234_5678;
    bus.ra0 = 5'd9;
    cycle("t1.pipe");
    bus.pipe_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("t1.rst_we", 64'(bus.we), 64'd0);
    check_eq("t1.rst_wa", 64'(bus.wa), 64'd0);
    check_eq("t1.rst_wd", 64'(bus.wd), 64'd0);
    check_eq("t1.rst_stall", 64'(bus.stall), 64'd0);
    m_busy = '0; m_refused = 0; exp_we = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_eq("t1.busy_cleared", 64'(bus.stall), 64'd0);
    cycle("t1.post");
    bus.ra0 = '0;

    // 2. Pipeline only
    bus.pipe_valid = 1'b1; bus.pipe_wa = 5'd5; bus.pipe_wd = 32'hDEAD_BEEF;
    cycle("t2.pipe");
    check_eq("t2.we", 64'(bus.we), 64'd1);
    check_eq("t2.wa", 64'(bus.wa), 64'd5);
    check_eq("t2.wd", 64'(bus.wd), 64'hDEAD_BEEF);
    bus.pipe_wa = 5'd0; bus.pipe_wd = 32'h1111_1111;
    cycle("t2.r0");
    check_eq("t2.r0_we", 64'(bus.we), 64'd0);
    bus.pipe_valid = 1'b0;

    // 3. Scoreboard RAW stall
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    cycle("t3.iss");
    bus.iss_valid = 1'b0; bus.ra0 = 5'd7;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("t3.stall_busy", 64'(bus.stall), 64'd1);
      cycle("t3.wait");
    end
    bus.lu_valid = 1'b1; bus.lu_wa = 5'd7; bus.lu_wd = 32'hA500_0007;
    cycle("t3.lu");
    bus.lu_valid = 1'b0;
    #1 check_eq("t3.stall_drop", 64'(bus.stall), 64'd0);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    cycle("t3.iss0");
    bus.iss_valid = 1'b0; bus.ra0 = '0;

    // 4. Starvation escape
    bus.pipe_valid = 1'b1; bus.pipe_wa = 5'd2; bus.pipe_wd = 32'h5A00_0002;
    bus.lu_valid   = 1'b1; bus.lu_wa   = 5'd4; bus.lu_wd   = 32'hA500_0004;
    for (int i = 0; i < STARVE_LIMIT + 1; i++) begin
      #1;
      check_eq("t4.lu_ready", 64'(bus.lu_ready), 64'(i == STARVE_LIMIT));
      check_eq("t4.pipe_hold", 64'(bus.pipe_hold), 64'(i == STARVE_LIMIT));
      cycle("t4.starve");
    end
    check_eq("t4.force_wa", 64'(bus.wa), 64'd4);
    check_eq("t4.force_wd", 64'(bus.wd), 64'hA500_0004);
    bus.lu_valid = 1'b0;
    cycle("t4.pipe_after");
    bus.pipe_valid = 1'b0;

    // 5. Same-cycle set and clear
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    bus.lu_valid  = 1'b1; bus.lu_wa  = 5'd9; bus.lu_wd = 32'hA500_0009;
    cycle("t5.setclr");
    bus.iss_valid = 1'b0; bus.lu_valid = 1'b0; bus.ra1 = 5'd9;
    #1 check_eq("t5.stall_kept", 64'(bus.stall), 64'd1);
    cycle("t5.check");
    bus.lu_valid = 1'b1; bus.lu_wd = 32'hA500_0019;
    cycle("t5.clear");
    bus.lu_valid = 1'b0;
    #1 check_eq("t5.stall_clear", 64'(bus.stall), 64'd0);
    bus.ra1 = '0;

    // 6. No pipeline pressure, then random mixed traffic
    bus.lu_valid = 1'b1; bus.lu_wa = 5'd12; bus.lu_wd = 32'hA500_000C;
    #1;
    check_eq("t6.lu_ready", 64'(bus.lu_ready), 64'd1);
    check_eq("t6.pipe_hold", 64'(bus.pipe_hold), 64'd0);
    cycle("t6.lu_only");
    bus.lu_valid = 1'b0;
    last_lu_acc = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!bus.lu_valid || last_lu_acc) begin
        bus.lu_valid = ($urandom_range(0, 2) != 0);
        bus.lu_wa    = 5'($urandom);
        bus.lu_wd    = {8'hA5, 24'($urandom)};
      end
      if (!(bus.pipe_valid && last_pipe_held)) begin
        bus.pipe_valid = ($urandom_range(0, 3) != 0);
        bus.pipe_wa    = 5'($urandom);
        bus.pipe_wd    = {8'h5A, 24'($urandom)};
      end
      bus.iss_valid = ($urandom_range(0, 1) != 0);
      bus.iss_rd    = 5'($urandom);
      bus.ra0       = 5'($urandom);
      bus.ra1       = 5'($urandom);
      cycle("t6.rand");
    end
    clear_inputs();
    cycle("t6.drain");
    check_eq("t6.lu_written_once", 64'(lu_wr_cnt), 64'(lu_acc_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
